// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the instruction/data memory bus arbiter: FSM states,
// stall-vector bit positions and small decode helpers used by the top.
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE     = 3'd0,
    ARB_IF_ACC   = 3'd1,
    ARB_MEM_ACC  = 3'd2,
    ARB_IF_HOLD  = 3'd3,
    ARB_MEM_HOLD = 3'd4
  } arb_state_e;

  localparam int STALL_W       = 6;
  localparam int STALL_IF_IDX  = 1;
  localparam int STALL_MEM_IDX = 4;

  // After an ack the requester either releases the bus or parks its data.
  function automatic arb_state_e acc_next(input logic stage_stalled,
                                          input arb_state_e hold_state);
    return stage_stalled ? hold_state : ARB_IDLE;
  endfunction

  function automatic logic is_if_state(input arb_state_e s);
    return (s == ARB_IF_ACC) || (s == ARB_IF_HOLD);
  endfunction

  function automatic logic is_mem_state(input arb_state_e s);
    return (s == ARB_MEM_ACC) || (s == ARB_MEM_HOLD);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Serialises IF and MEM requests onto one registered req/ack bus, MEM first; stall held until ack.
// Read data passes through on the ack cycle, or is parked in a buffer while the owning stage is stalled.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = DATA_W / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               if_ce_i,
  input  logic [ADDR_W-1:0]  if_addr_i,
  output logic [DATA_W-1:0]  if_data_o,
  output logic               if_stallreq_o,
  input  logic               mem_ce_i,
  input  logic               mem_we_i,
  input  logic [SEL_W-1:0]   mem_sel_i,
  input  logic [ADDR_W-1:0]  mem_addr_i,
  input  logic [DATA_W-1:0]  mem_data_i,
  output logic [DATA_W-1:0]  mem_data_o,
  output logic               mem_stallreq_o,
  output logic               bus_req_o,
  output logic               bus_we_o,
  output logic [SEL_W-1:0]   bus_sel_o,
  output logic [ADDR_W-1:0]  bus_addr_o,
  output logic [DATA_W-1:0]  bus_data_o,
  input  logic [DATA_W-1:0]  bus_data_i,
  input  logic               bus_ack_i
);

  arb_state_e         state_q, state_d;
  logic               bus_req_q, bus_req_d;
  logic               bus_we_q, bus_we_d;
  logic [SEL_W-1:0]   bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]  bus_data_q, bus_data_d;
  logic [DATA_W-1:0]  if_buf_q, if_buf_d;
  logic [DATA_W-1:0]  mem_buf_q, mem_buf_d;
  logic               discard_q, discard_d;

  logic if_stage_stalled;
  logic mem_stage_stalled;
  logic if_acc_ack;
  logic mem_acc_ack;
  logic if_drop;

  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[5], stall[3:2], stall[0]};

  assign if_stage_stalled  = stall[STALL_IF_IDX];
  assign mem_stage_stalled = stall[STALL_MEM_IDX];
  assign if_acc_ack        = (state_q == ARB_IF_ACC)  && bus_ack_i;
  assign mem_acc_ack       = (state_q == ARB_MEM_ACC) && bus_ack_i;
  // A flush seen at any point of the fetch, including the ack cycle itself, kills its data.
  assign if_drop           = discard_q || flush;

  always_comb begin
    state_d    = state_q;
    bus_req_d  = bus_req_q;
    bus_we_d   = bus_we_q;
    bus_sel_d  = bus_sel_q;
    bus_addr_d = bus_addr_q;
    bus_data_d = bus_data_q;
    if_buf_d   = if_buf_q;
    mem_buf_d  = mem_buf_q;
    discard_d  = discard_q;

    unique case (state_q)
      ARB_IDLE: begin
        discard_d = 1'b0;
        if (mem_ce_i) begin
          bus_req_d  = 1'b1;
          bus_we_d   = mem_we_i;
          bus_sel_d  = mem_sel_i;
          bus_addr_d = mem_addr_i;
          bus_data_d = mem_data_i;
          state_d    = ARB_MEM_ACC;
        end else if (if_ce_i && !flush) begin
          bus_req_d  = 1'b1;
          bus_we_d   = 1'b0;
          bus_sel_d  = {SEL_W{1'b1}};
          bus_addr_d = if_addr_i;
          bus_data_d = '0;
          state_d    = ARB_IF_ACC;
        end
      end

      ARB_IF_ACC: begin
        if (flush) begin
          discard_d = 1'b1;
        end
        if (bus_ack_i) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          if (if_drop) begin
            if_buf_d  = '0;
            discard_d = 1'b0;
            state_d   = ARB_IDLE;
          end else begin
            if_buf_d = bus_data_i;
            state_d  = acc_next(if_stage_stalled, ARB_IF_HOLD);
          end
        end
      end

      ARB_MEM_ACC: begin
        if (bus_ack_i) begin
          bus_req_d = 1'b0;
          bus_we_d  = 1'b0;
          mem_buf_d = bus_we_q ? '0 : bus_data_i;
          state_d   = acc_next(mem_stage_stalled, ARB_MEM_HOLD);
        end
      end

      ARB_IF_HOLD: begin
        if (flush) begin
          if_buf_d = '0;
          state_d  = ARB_IDLE;
        end else if (!if_stage_stalled) begin
          state_d = ARB_IDLE;
        end
      end

      ARB_MEM_HOLD: begin
        if (!mem_stage_stalled) begin
          state_d = ARB_IDLE;
        end
      end

      default: begin
        state_d   = ARB_IDLE;
        bus_req_d = 1'b0;
        bus_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      bus_req_q  <= 1'b0;
      bus_we_q   <= 1'b0;
      bus_sel_q  <= '0;
      bus_addr_q <= '0;
      bus_data_q <= '0;
      if_buf_q   <= '0;
      mem_buf_q  <= '0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bus_req_q  <= bus_req_d;
      bus_we_q   <= bus_we_d;
      bus_sel_q  <= bus_sel_d;
      bus_addr_q <= bus_addr_d;
      bus_data_q <= bus_data_d;
      if_buf_q   <= if_buf_d;
      mem_buf_q  <= mem_buf_d;
      discard_q  <= discard_d;
    end
  end

  // Data and stall outputs are forced quiet while reset is held.
  always_comb begin
    if_data_o      = '0;
    mem_data_o     = '0;
    if_stallreq_o  = 1'b0;
    mem_stallreq_o = 1'b0;
    if (rst) begin
      if (if_acc_ack && !if_drop) begin
        if_data_o = bus_data_i;
      end else if (state_q == ARB_IF_HOLD) begin
        if_data_o = if_buf_q;
      end

      if (mem_acc_ack && !bus_we_q) begin
        mem_data_o = bus_data_i;
      end else if (state_q == ARB_MEM_HOLD) begin
        mem_data_o = mem_buf_q;
      end

      if_stallreq_o  = if_ce_i && !if_acc_ack && (state_q != ARB_IF_HOLD) && !flush;
      mem_stallreq_o = mem_ce_i && !mem_acc_ack && (state_q != ARB_MEM_HOLD);
    end
  end

  assign bus_req_o  = bus_req_q;
  assign bus_we_o   = bus_we_q;
  assign bus_sel_o  = bus_sel_q;
  assign bus_addr_o = bus_addr_q;
  assign bus_data_o = bus_data_q;

endmodule
